// File: rtl/ps_byte_if.sv
// Byte-source / serializer bundle for the clk32_f parallel-to-serial lane.
// master drives request bytes, slave schedules them onto the serializer.
interface ps_byte_if #(
  parameter int NREQ   = 2,
  parameter int DATA_W = 8
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        req_ready;
  logic [DATA_W-1:0]      ser_data;
  logic                   ser_valid;
  logic                   ser_load;
  logic [2:0]             bit_phase;
  logic                   link_up;

  modport master (
    output req_valid, req_data,
    input  req_ready, ser_data, ser_valid,
    input  ser_load, bit_phase, link_up
  );

  modport slave (
    input  req_valid, req_data,
    output req_ready, ser_data, ser_valid,
    output ser_load, bit_phase, link_up
  );
endinterface

// File: rtl/ps_byte_scheduler.sv
// Round-robin byte scheduler feeding one serializer at 8-cycle byte
// boundaries, with an idle-symbol INIT preamble after reset.
module ps_byte_scheduler #(
  parameter int                NREQ      = 2,
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] IDLE_SYM  = 8'hBC,
  parameter int                INIT_IDLE = 4
) (
  input logic      clk32_f,
  input logic      reset,
  ps_byte_if.slave bus
);
  localparam int LW = $clog2(NREQ);
  localparam int CW = $clog2(INIT_IDLE + 1);

  typedef enum logic {
    S_INIT,
    S_ACTIVE
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [2:0]        phase_q;
  logic [CW-1:0]     idle_cnt_q;
  logic [LW-1:0]     last_q;
  logic [LW-1:0]     cand;
  logic [LW-1:0]     gnt_idx;
  logic              gnt_any;
  logic [NREQ-1:0]   gnt_oh;
  logic [NREQ-1:0]   ready;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              load_q;
  logic              link_up;
  logic              boundary;
  logic              init_done;
  logic [DATA_W-1:0] req_byte [NREQ];

  assign boundary  = phase_q == 3'd7;
  assign init_done = idle_cnt_q == CW'(INIT_IDLE - 1);

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign req_byte[i] = bus.req_data[i*DATA_W +: DATA_W];
  end

  // Search starts one past the last winner so every source gets a turn.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = LW'((int'(last_q) + k) % NREQ);
      if (!gnt_any && bus.req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    gnt_oh = '0;
    if (gnt_any) gnt_oh[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk32_f) begin
    if (reset) state_q <= S_INIT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_INIT:   if (boundary && init_done) state_d = S_ACTIVE;
      S_ACTIVE: state_d = S_ACTIVE;
      default:  state_d = S_INIT;
    endcase
  end

  always_comb begin
    ready   = '0;
    link_up = 1'b0;
    unique case (state_q)
      S_INIT: ready = '0;
      S_ACTIVE: begin
        link_up = 1'b1;
        if (boundary && !reset) ready = gnt_oh;
      end
      default: ready = '0;
    endcase
  end

  always_ff @(posedge clk32_f) begin
    if (reset) begin
      phase_q    <= 3'd0;
      idle_cnt_q <= '0;
      last_q     <= LW'(NREQ - 1);
      data_q     <= IDLE_SYM;
      valid_q    <= 1'b0;
      load_q     <= 1'b0;
    end else begin
      phase_q <= phase_q + 3'd1;
      load_q  <= boundary;
      if (boundary) begin
        if (state_q == S_INIT) begin
          data_q     <= IDLE_SYM;
          valid_q    <= 1'b0;
          idle_cnt_q <= idle_cnt_q + CW'(1);
        end else if (gnt_any) begin
          data_q  <= req_byte[gnt_idx];
          valid_q <= 1'b1;
          last_q  <= gnt_idx;
        end else begin
          data_q  <= IDLE_SYM;
          valid_q <= 1'b0;
        end
      end
    end
  end

  assign bus.req_ready = ready;
  assign bus.ser_data  = data_q;
  assign bus.ser_valid = valid_q;
  assign bus.ser_load  = load_q;
  assign bus.bit_phase = phase_q;
  assign bus.link_up   = link_up;
endmodule

// File: tb/tb_ps_byte_scheduler.sv
// Scoreboard bench for ps_byte_scheduler: directed bytes push expected
// grants/loads, a monitor pops and compares at each boundary and load.
module tb_ps_byte_scheduler;
  logic clk32_f;
  logic reset;
  logic run;
  int   n_pass;
  int   n_total;

  typedef struct packed {
    logic [7:0] data;
    logic       valid;
    logic       link;
  } load_t;

  load_t      load_q [$];
  logic [1:0] rdy_q  [$];

  ps_byte_if #(.NREQ(2), .DATA_W(8)) bus ();

  ps_byte_scheduler #(
    .NREQ(2),
    .DATA_W(8),
    .IDLE_SYM(8'hBC),
    .INIT_IDLE(4)
  ) dut (
    .clk32_f(clk32_f),
    .reset(reset),
    .bus(bus)
  );

  initial clk32_f = 1'b0;
  always #5 clk32_f = ~clk32_f;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
  endtask

  task automatic miss(input string name);
    n_total++;
    $display("FAIL %s: no expectation queued at %0t", name, $time);
  endtask

  task automatic do_byte(
    input logic [1:0] base, input logic [1:0] pulse,
    input int plo, input int phi,
    input logic [7:0] d0, input logic [7:0] d1,
    input logic [1:0] rdy,
    input logic [7:0] ed, input logic ev, input logic el
  );
    load_t e;
    e = {ed, ev, el};
    rdy_q.push_back(rdy);
    load_q.push_back(e);
    bus.req_data = {d1, d0};
    for (int p = 0; p < 8; p++) begin
      bus.req_valid = base | ((p >= plo && p <= phi) ? pulse : 2'b00);
      @(negedge clk32_f);
    end
  endtask

  task automatic plain(input logic [1:0] v, input logic [7:0] d0,
                       input logic [7:0] d1, input logic [1:0] rdy,
                       input logic [7:0] ed, input logic ev,
                       input logic el);
    do_byte(v, 2'b00, 1, 0, d0, d1, rdy, ed, ev, el);
  endtask

  initial begin
    load_t got;
    wait (run);
    forever begin
      @(negedge clk32_f);
      #1;
      if (!reset) begin
        if (bus.bit_phase == 3'd7) begin
          if (rdy_q.size() == 0) miss("req_ready");
          else chk("req_ready", bus.req_ready, rdy_q.pop_front());
        end else begin
          chk("ready_off", bus.req_ready, 2'b00);
        end
        if (bus.ser_load) begin
          chk("load_phase", bus.bit_phase, 3'd0);
          if (load_q.size() == 0) miss("ser_load");
          else begin
            got = load_q.pop_front();
            chk("ser_data", bus.ser_data, got.data);
            chk("ser_valid", bus.ser_valid, got.valid);
            chk("link_up", bus.link_up, got.link);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    n_total++;
    $display("FAIL watchdog: timeout at %0t", $time);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    n_pass        = 0;
    n_total       = 0;
    run           = 1'b0;
    reset         = 1'b1;
    bus.req_valid = 2'b00;
    bus.req_data  = 16'h0000;
    repeat (3) @(negedge clk32_f);
    chk("rst_phase", bus.bit_phase, 3'd0);
    chk("rst_data", bus.ser_data, 8'hBC);
    chk("rst_valid", bus.ser_valid, 1'b0);
    chk("rst_load", bus.ser_load, 1'b0);
    chk("rst_link", bus.link_up, 1'b0);
    chk("rst_ready", bus.req_ready, 2'b00);
    run   = 1'b1;
    reset = 1'b0;

    // INIT preamble with both sources pending
    plain(2'b11, 8'h11, 8'h22, 2'b00, 8'hBC, 1'b0, 1'b0);
    plain(2'b11, 8'h11, 8'h22, 2'b00, 8'hBC, 1'b0, 1'b0);
    plain(2'b11, 8'h11, 8'h22, 2'b00, 8'hBC, 1'b0, 1'b0);
    plain(2'b11, 8'h11, 8'h22, 2'b00, 8'hBC, 1'b0, 1'b1);

    // single source, then idle
    plain(2'b01, 8'h5A, 8'h00, 2'b01, 8'h5A, 1'b1, 1'b1);
    plain(2'b00, 8'h5A, 8'h00, 2'b00, 8'hBC, 1'b0, 1'b1);
    plain(2'b10, 8'h00, 8'h33, 2'b10, 8'h33, 1'b1, 1'b1);

    // both valid: alternate starting at req0
    plain(2'b11, 8'h11, 8'h22, 2'b01, 8'h11, 1'b1, 1'b1);
    plain(2'b11, 8'h11, 8'h22, 2'b10, 8'h22, 1'b1, 1'b1);
    plain(2'b11, 8'h11, 8'h22, 2'b01, 8'h11, 1'b1, 1'b1);
    plain(2'b11, 8'h11, 8'h22, 2'b10, 8'h22, 1'b1, 1'b1);

    // req1 again after its own grant, then req0 wins
    plain(2'b10, 8'h00, 8'h44, 2'b10, 8'h44, 1'b1, 1'b1);
    plain(2'b11, 8'h55, 8'h66, 2'b01, 8'h55, 1'b1, 1'b1);

    // pulse between boundaries is lost; pulse at phase 7 is taken
    do_byte(2'b00, 2'b10, 2, 5, 8'h00, 8'h77, 2'b00, 8'hBC, 1'b0, 1'b1);
    do_byte(2'b00, 2'b10, 7, 7, 8'h00, 8'h77, 2'b10, 8'h77, 1'b1, 1'b1);

    // reset mid-byte at phase 3
    bus.req_valid = 2'b01;
    bus.req_data  = {8'h00, 8'h99};
    repeat (3) @(negedge clk32_f);
    chk("pre_rst_phase", bus.bit_phase, 3'd3);
    reset = 1'b1;
    @(negedge clk32_f);
    chk("mid_rst_phase", bus.bit_phase, 3'd0);
    chk("mid_rst_link", bus.link_up, 1'b0);
    chk("mid_rst_data", bus.ser_data, 8'hBC);
    chk("mid_rst_valid", bus.ser_valid, 1'b0);
    reset = 1'b0;
    plain(2'b01, 8'h99, 8'h00, 2'b00, 8'hBC, 1'b0, 1'b0);
    plain(2'b01, 8'h99, 8'h00, 2'b00, 8'hBC, 1'b0, 1'b0);
    plain(2'b01, 8'h99, 8'h00, 2'b00, 8'hBC, 1'b0, 1'b0);
    plain(2'b01, 8'h99, 8'h00, 2'b00, 8'hBC, 1'b0, 1'b1);
    plain(2'b01, 8'h99, 8'h00, 2'b01, 8'h99, 1'b1, 1'b1);

    bus.req_valid = 2'b00;
    repeat (2) @(negedge clk32_f);
    #2;
    chk("rdy_q_empty", rdy_q.size(), 0);
    chk("load_q_empty", load_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
